digit_scanner: RTL and testbench
================================

DIGIT_SCANNER -- requirements
Module: digit_scanner

Interface
REQ-001 Parameter DIV, default 12000, clock cycles each digit is shown; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 digits  input  16  four BCD digits; [3:0] digit 0 (rightmost) ... [15:12] digit 3 (leftmost).
REQ-005 neg  input  1  show minus sign in digit 3 position.
REQ-006 bcd  output  4  code for the downstream BCD-to-segment mapper: 0..9 digit, 4'b1011 minus, 4'b1111 blank.
REQ-007 digit_en  output  4  one-hot, active-high select of the digit currently driven on bcd.
REQ-008 frame_start  output  1  one-cycle pulse marking start of a new 4-digit frame.

Function
REQ-009 Prescaler cnt (16 bit) SHALL count 0..DIV-1 and wrap to 0; tick = (cnt == DIV-1).
REQ-010 Digit index idx (2 bit) SHALL increment modulo 4 on the edge where tick is true, else hold.
REQ-011 Shadow register SHALL capture digits and neg on the tick edge where idx goes 3 -> 0 (frame boundary), and at no other time.
REQ-012 bcd and digit_en SHALL be registered and update on the same edge as idx; digit_en = 1 << new idx.
REQ-013 At a frame boundary, the bcd value for digit 0 SHALL be derived from the values being captured on that edge, not the old shadow.
REQ-014 bcd SHALL equal the shadow nibble at the new idx, except the minus and blanking rules below; nibbles >9 other than the overrides pass through unchanged.
REQ-015 When shadow neg = 1, bcd for idx 3 SHALL be 4'b1011 regardless of digit 3 value.
REQ-016 frame_start SHALL be 1 exactly in the cycle after a frame-boundary edge, 0 otherwise.
REQ-017 Each digit SHALL be displayed for exactly DIV cycles; frame period is exactly 4*DIV cycles.
REQ-018 Changes on digits/neg between frame boundaries SHALL NOT affect outputs until the next boundary.

Reset
REQ-019 On rst = 1: cnt = 0, idx = 0, shadow digits = 0, shadow neg = 0, digit_en = 4'b0001, bcd = 4'b0000, frame_start = 0.
REQ-020 rst asserted mid-frame SHALL discard the frame; first tick occurs DIV cycles after rst deasserts.
REQ-021 The first frame boundary after reset SHALL occur 4*DIV cycles after rst deasserts.

Configuration
REQ-022 Macro LEADING_ZERO_BLANK_EN SHALL, when defined, enable leading-zero blanking; when undefined all positions show their nibble (minus rule still applies).
REQ-023 With LEADING_ZERO_BLANK_EN: positions 3..1 output 4'b1111 when that nibble and every more-significant non-minus nibble are 0; digit 0 is never blanked.
REQ-024 With LEADING_ZERO_BLANK_EN and neg = 1: position 3 shows minus, and blanking of positions 2..1 is evaluated from position 2 downward.

Verification (bench uses DIV = 4)
REQ-025 rst high 2 cycles, then release -> digit_en 0001, bcd 0000; digit_en 0010 after 4 cycles; first frame_start pulse 16 cycles after release.
REQ-026 digits = 16'h1234, neg = 0, after first boundary -> bcd sequence 4,3,2,1 with digit_en 0001,0010,0100,1000, 4 cycles each.
REQ-027 digits change 16'h1234 -> 16'h5678 mid-frame -> remaining digits still show 16'h1234 values; next frame shows 8,7,6,5.
REQ-028 digits = 16'h0007, neg = 1 -> without macro: 7,0,0,1011; with LEADING_ZERO_BLANK_EN: 7,1111,1111,1011.
REQ-029 digits = 16'h0000 with LEADING_ZERO_BLANK_EN -> 0,1111,1111,1111; digits = 16'h0A05 -> 5,0,A,1111.
REQ-030 rst pulsed while idx = 2 -> next cycle digit_en 0001, bcd 0000, frame_start 0; prescaler restarts from 0.

Source files
------------

// File: rtl/digit_scanner.sv
// Four-digit multiplexed display scanner: a prescaler steps a digit index,
// and the inputs are latched once per frame. Optional macro: LEADING_ZERO_BLANK_EN.
module digit_scanner #(
  parameter int DIV = 12000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic        neg,
  output logic [3:0]  bcd,
  output logic [3:0]  digit_en,
  output logic        frame_start
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt;
  logic [1:0]  idx;
  logic [15:0] sh_digits;
  logic        sh_neg;

  logic        tick;
  logic        boundary;
  logic [1:0]  idx_n;
  logic [15:0] src_digits;
  logic        src_neg;
  logic [3:0]  bcd_n;

  // Display code for position i of a latched frame (minus sign, optional blanking).
  function automatic logic [3:0] pick(input logic [15:0] d, input logic n, input logic [1:0] i);
    logic [3:0] nib;
    logic       blank;
    nib   = d[{i, 2'b00} +: 4];
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (i)
      2'd3:    blank = (d[15:12] == 4'h0);
      2'd2:    blank = (n || d[15:12] == 4'h0) && (d[11:8] == 4'h0);
      2'd1:    blank = (n || d[15:12] == 4'h0) && (d[11:4] == 8'h00);
      default: blank = 1'b0;
    endcase
`endif
    if (n && i == 2'd3)
      pick = 4'b1011;
    else if (blank)
      pick = 4'b1111;
    else
      pick = nib;
  endfunction

  // At the frame boundary digit 0 must reflect the values being latched now.
  always_comb begin
    tick       = (cnt == LAST);
    boundary   = tick && (idx == 2'd3);
    idx_n      = idx + 2'd1;
    src_digits = boundary ? digits : sh_digits;
    src_neg    = boundary ? neg : sh_neg;
    bcd_n      = pick(src_digits, src_neg, idx_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      sh_digits   <= '0;
      sh_neg      <= 1'b0;
      digit_en    <= 4'b0001;
      bcd         <= 4'b0000;
      frame_start <= 1'b0;
    end else begin
      cnt         <= tick ? 16'd0 : cnt + 16'd1;
      frame_start <= boundary;
      if (tick) begin
        idx      <= idx_n;
        digit_en <= 4'b0001 << idx_n;
        bcd      <= bcd_n;
      end
      if (boundary) begin
        sh_digits <= digits;
        sh_neg    <= neg;
      end
    end
  end

endmodule

// File: tb/tb_digit_scanner.sv
// Randomized and directed bench for digit_scanner (DIV = 4) against a time-based
// behavioural model: position = (cycles since reset / DIV) mod 4, latch every 4*DIV.
module tb_digit_scanner;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic        neg;
  logic [3:0]  bcd;
  logic [3:0]  digit_en;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  // model state
  int          k;
  logic [15:0] m_dig;
  logic        m_neg;
  logic        m_fs;

  digit_scanner #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .digits(digits), .neg(neg),
    .bcd(bcd), .digit_en(digit_en), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic adv();
    @(posedge clk);
    if (rst) begin
      k = 0; m_dig = '0; m_neg = 1'b0; m_fs = 1'b0;
    end else begin
      k++;
      m_fs = (k % (4 * DIV) == 0);
      if (m_fs) begin m_dig = digits; m_neg = neg; end
    end
    #1;
  endtask

  function automatic int exp_pos();
    return (k / DIV) % 4;
  endfunction

  function automatic logic [3:0] exp_en();
    logic [3:0] one;
    one = 4'b0001;
    return one << exp_pos();
  endfunction

  function automatic logic [3:0] exp_bcd();
    int          p;
    logic [15:0] t;
    logic [3:0]  nib;
    logic        blank;
    p   = exp_pos();
    t   = m_dig >> (4 * p);
    nib = t[3:0];
    if (p == 3 && m_neg) return 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
    if (p != 0 && nib == 4'h0) begin
      blank = 1'b1;
      for (int j = p + 1; j < 4; j++) begin
        t = m_dig >> (4 * j);
        if (!(j == 3 && m_neg) && t[3:0] != 4'h0) blank = 1'b0;
      end
      if (blank) return 4'b1111;
    end
`else
    blank = 1'b0;
    if (blank) return 4'b1111;
`endif
    return nib;
  endfunction

  task automatic test_reset();
    int n;
    rst = 1'b1; digits = 16'h1234; neg = 1'b0;
    adv(); adv();
    checks++; if (digit_en !== 4'b0001) begin failures++; $display("FAIL reset_en got=%b want=0001", digit_en); end
    checks++; if (bcd !== 4'b0000) begin failures++; $display("FAIL reset_bcd got=%h want=0", bcd); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b want=0", frame_start); end
    rst = 1'b0;
    n = 0;
    while (frame_start !== 1'b1 && n < 40) begin
      adv(); n++;
      checks++; if (digit_en !== exp_en()) begin failures++; $display("FAIL first_en k=%0d got=%b want=%b", k, digit_en, exp_en()); end
      checks++; if (bcd !== exp_bcd()) begin failures++; $display("FAIL first_bcd k=%0d got=%h want=%h", k, bcd, exp_bcd()); end
    end
    checks++; if (n != 4 * DIV) begin failures++; $display("FAIL first_frame_start got=%0d want=%0d cycles", n, 4 * DIV); end
  endtask

  task automatic test_midframe_change();
    for (int c = 0; c < 4 * DIV + 6; c++) begin
      adv();
      checks++; if (bcd !== exp_bcd()) begin failures++; $display("FAIL scan_bcd k=%0d got=%h want=%h", k, bcd, exp_bcd()); end
      checks++; if (digit_en !== exp_en()) begin failures++; $display("FAIL scan_en k=%0d got=%b want=%b", k, digit_en, exp_en()); end
      checks++; if (frame_start !== m_fs) begin failures++; $display("FAIL scan_fs k=%0d got=%b want=%b", k, frame_start, m_fs); end
    end
    digits = 16'h5678;
    for (int c = 0; c < 8 * DIV; c++) begin
      adv();
      checks++; if (bcd !== exp_bcd()) begin failures++; $display("FAIL change_bcd k=%0d got=%h want=%h", k, bcd, exp_bcd()); end
      checks++; if (digit_en !== exp_en()) begin failures++; $display("FAIL change_en k=%0d got=%b want=%b", k, digit_en, exp_en()); end
      checks++; if (frame_start !== m_fs) begin failures++; $display("FAIL change_fs k=%0d got=%b want=%b", k, frame_start, m_fs); end
    end
  endtask

  task automatic test_patterns();
    logic [15:0] pat [3];
    logic        pneg [3];
    pat[0] = 16'h0007; pneg[0] = 1'b1;
    pat[1] = 16'h0000; pneg[1] = 1'b0;
    pat[2] = 16'h0A05; pneg[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      digits = pat[i]; neg = pneg[i];
      for (int c = 0; c < 8 * DIV; c++) begin
        adv();
        checks++; if (bcd !== exp_bcd()) begin failures++; $display("FAIL pat_bcd d=%h k=%0d got=%h want=%h", pat[i], k, bcd, exp_bcd()); end
        checks++; if (digit_en !== exp_en()) begin failures++; $display("FAIL pat_en d=%h k=%0d got=%b want=%b", pat[i], k, digit_en, exp_en()); end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 24 * DIV; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        digits = 16'($urandom);
        if ($urandom_range(0, 1) == 0) digits[15:8] = 8'h00;
        neg = 1'($urandom_range(0, 1));
      end
      adv();
      checks++; if (bcd !== exp_bcd()) begin failures++; $display("FAIL rand_bcd k=%0d got=%h want=%h", k, bcd, exp_bcd()); end
      checks++; if (digit_en !== exp_en()) begin failures++; $display("FAIL rand_en k=%0d got=%b want=%b", k, digit_en, exp_en()); end
      checks++; if (frame_start !== m_fs) begin failures++; $display("FAIL rand_fs k=%0d got=%b want=%b", k, frame_start, m_fs); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (exp_pos() != 2 && n < 20) begin adv(); n++; end
    adv();
    rst = 1'b1;
    adv();
    rst = 1'b0;
    checks++; if (digit_en !== 4'b0001) begin failures++; $display("FAIL midrst_en got=%b want=0001", digit_en); end
    checks++; if (bcd !== 4'b0000) begin failures++; $display("FAIL midrst_bcd got=%h want=0", bcd); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL midrst_fs got=%b want=0", frame_start); end
    n = 0;
    while (digit_en !== 4'b0010 && n < 20) begin adv(); n++; end
    checks++; if (n != DIV) begin failures++; $display("FAIL midrst_first_tick got=%0d want=%0d cycles", n, DIV); end
    for (int c = 0; c < 4 * DIV; c++) begin
      adv();
      checks++; if (bcd !== exp_bcd()) begin failures++; $display("FAIL midrst_bcd k=%0d got=%h want=%h", k, bcd, exp_bcd()); end
      checks++; if (frame_start !== m_fs) begin failures++; $display("FAIL midrst_fs k=%0d got=%b want=%b", k, frame_start, m_fs); end
    end
  endtask

  initial begin
    test_reset();
    test_midframe_change();
    test_patterns();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
